lf_add_sched: RTL and testbench

- Round-robin scheduler that shares one 32-bit Ladner-Fischer prefix adder among NREQ requesters.
- Each requester streams a burst of 32-bit operand word pairs, least significant word first.
- Carry is chained across the words of a burst, so the single adder serves 32·k-bit additions.
- Sits between requester blocks and the adder datapath. Holds the grant for a whole burst and registers one result word per accepted operand pair.

---
 rtl/lf_add_pkg.sv | 39 +++
 rtl/lf_add32_cin.sv | 41 ++++
 rtl/lf_add_sched.sv | 139 +++++++++++++
 tb/tb_lf_add_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lf_add_pkg.sv
// Shared definitions for the Ladner-Fischer add scheduler.
//   WORD_W  : datapath word width (one operand word per accepted pair)
//   MAX_REQ : widest requester vector the round-robin helper handles
//   state_t : scheduler FSM state
//   black   : prefix combine cell on {g,p} pairs
//   rr_pick : round-robin winner search starting just above last_grant
package lf_add_pkg;

    localparam int WORD_W  = 32;
    localparam int MAX_REQ = 8;

    typedef enum logic {IDLE, BURST} state_t;

    // {g,p} combine: hi spans the more significant bits, lo the less significant.
    function automatic logic [1:0] black(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    // First set bit of valid, searching upward from last_grant+1 and wrapping
    // at nreq. Returns last_grant unchanged when nothing is valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last_grant,
                                           input int                 nreq);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = last_grant;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(last_grant) + k) % nreq;
            if (k <= nreq && !found && valid[idx]) begin
                win   = 3'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/lf_add32_cin.sv
// Combinational 32-bit Ladner-Fischer (minimum-depth) prefix adder with carry-in.
//   a, b : operands
//   cin  : carry-in, injected as the generate of bit position -1
//   sum  : a + b + cin, low 32 bits
//   cout : carry out of bit 31
module lf_add32_cin
    import lf_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    // Node 0 carries cin, node i (1..32) holds bit i-1. After the prefix tree
    // node i's generate is the carry into bit i.
    localparam int N  = WORD_W + 1;
    localparam int LV = $clog2(N);

    logic [1:0]        pf [N];
    logic [WORD_W-1:0] prop;

    always_comb begin
        prop = a ^ b;
        pf[0] = {cin, 1'b0};
        for (int i = 1; i < N; i++)
            pf[i] = {a[i-1] & b[i-1], prop[i-1]};
        // At level lv, nodes with bit lv set absorb the top node of the block
        // just below them; that node has bit lv clear and is untouched this
        // level, so updating in place is safe.
        for (int lv = 0; lv < LV; lv++)
            for (int k = 0; k < N; k++)
                if (((k >> lv) & 1) == 1)
                    pf[k] = black(pf[k], pf[((k >> lv) << lv) - 1]);
        for (int i = 0; i < WORD_W; i++)
            sum[i] = prop[i] ^ pf[i][1];
        cout = pf[N-1][1];
    end

endmodule

// File: rtl/lf_add_sched.sv
// Round-robin scheduler sharing one 32-bit prefix adder among NREQ requesters.
// A granted requester streams a burst of word pairs, LS word first; the carry is
// chained across the burst and one result word is registered per accepted pair.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/ready        : per-requester word handshake
//   req_a, req_b           : packed operands, requester i at [32i+31:32i]
//   req_last               : final (most significant) word of a burst
//   req_sub                : subtract burst, sampled on the first word
//                            (present only with LFADD_SUB_EN defined)
//   res_valid/ready        : result handshake
//   res_sum/cout/last/id   : result word, its carry out, burst end, owner
// Optional feature macro: LFADD_SUB_EN (burst-wide A-B).
module lf_add_sched
    import lf_add_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_last,
`ifdef LFADD_SUB_EN
    input  logic [NREQ-1:0]        req_sub,
`endif
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WORD_W-1:0]      res_sum,
    output logic                   res_cout,
    output logic                   res_last,
    output logic [IDW-1:0]         res_id
);

    state_t            state;
    logic [IDW-1:0]    grant;
    logic [IDW-1:0]    last_grant;
    logic              carry_reg;

    logic [WORD_W-1:0] sel_a, sel_b, b_op;
    logic              sel_last, cin, slot_free, accept;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;
    logic [2:0]        winner;

    assign sel_a     = req_a[int'(grant)*WORD_W +: WORD_W];
    assign sel_b     = req_b[int'(grant)*WORD_W +: WORD_W];
    assign sel_last  = req_last[grant];
    // The result slot is free when empty or being drained this cycle.
    assign slot_free = !res_valid || res_ready;
    assign accept    = (state == BURST) && req_valid[grant] && slot_free;
    assign winner    = rr_pick(MAX_REQ'(req_valid), 3'(last_grant), NREQ);

`ifdef LFADD_SUB_EN
    logic first_reg, sub_reg, sub_eff;
    // Mode comes straight from the requester on the first word, then is held.
    assign sub_eff = first_reg ? req_sub[grant] : sub_reg;
    assign b_op    = sel_b ^ {WORD_W{sub_eff}};
    assign cin     = first_reg ? sub_eff : carry_reg;
`else
    assign b_op    = sel_b;
    assign cin     = carry_reg;
`endif

    always_comb begin
        req_ready = '0;
        if (state == BURST)
            req_ready[grant] = slot_free;
    end

    lf_add32_cin u_add (
        .a    (sel_a),
        .b    (b_op),
        .cin  (cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDW'(NREQ - 1);
            carry_reg  <= 1'b0;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            res_last   <= 1'b0;
            res_id     <= '0;
`ifdef LFADD_SUB_EN
            first_reg  <= 1'b0;
            sub_reg    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                res_valid <= 1'b1;
                res_sum   <= add_sum;
                res_cout  <= add_cout;
                res_last  <= sel_last;
                res_id    <= grant;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Arbitration ignores the result slot; the stall happens
                    // through req_ready once in BURST.
                    if (|req_valid) begin
                        grant     <= IDW'(winner);
                        carry_reg <= 1'b0;
                        state     <= BURST;
`ifdef LFADD_SUB_EN
                        first_reg <= 1'b1;
`endif
                    end
                end
                BURST: begin
                    if (accept) begin
                        carry_reg <= add_cout;
`ifdef LFADD_SUB_EN
                        first_reg <= 1'b0;
                        sub_reg   <= sub_eff;
`endif
                        if (sel_last) begin
                            carry_reg  <= 1'b0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lf_add_sched.sv
// Directed bench for lf_add_sched: vector table plus hand-written sequences
// for round-robin, output stall and mid-burst reset.
module tb_lf_add_sched;
    import lf_add_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WORD_W-1:0] req_a, req_b;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_sub;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid, res_ready;
    logic [WORD_W-1:0]      res_sum;
    logic                   res_cout, res_last;
    logic [IDW-1:0]         res_id;

    always #5 clk = ~clk;

    lf_add_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
`ifdef LFADD_SUB_EN
        .req_sub   (req_sub),
`endif
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_last  (res_last),
        .res_id    (res_id)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] sum, input logic cout,
                           input logic last, input int id);
        chk({tag, ".valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".sum"},   res_sum,         sum);
        chk({tag, ".cout"},  32'(res_cout),   32'(cout));
        chk({tag, ".last"},  32'(res_last),   32'(last));
        chk({tag, ".id"},    32'(res_id),     32'(id));
    endtask

    // Present one word on requester id and wait (bounded) for its acceptance.
    // Returns #1 after the accepting edge with req_valid[id] dropped.
    task automatic put_word(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic last, input logic sub, output logic ok);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_last[id]       = last;
        req_sub[id]        = sub;
        req_valid[id]      = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: req %0d never accepted, expected accept within 50 cycles", id);
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic        ok;
    int          got;
    int          rr_id  [4] = '{0, 2, 0, 2};
    logic [31:0] rr_sum [4] = '{32'h11, 32'h22, 32'h11, 32'h22};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_last  = '0;
        req_sub   = '0;
        res_ready = 1'b1;

        //            id  a              b              last sub  sum            cout
        vt.push_back('{0, 32'h3a6f36e3, 32'hf6af8732, 1'b1, 1'b0, 32'h311EBE15, 1'b1});
        vt.push_back('{1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1});
        vt.push_back('{1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0});
        vt.push_back('{3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b1});
        vt.push_back('{2, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
        vt.push_back('{2, 32'h00000005, 32'h00000006, 1'b0, 1'b0, 32'h0000000C, 1'b0});
        vt.push_back('{2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0});
        vt.push_back('{0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b0});
`ifdef LFADD_SUB_EN
        vt.push_back('{0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0});
        vt.push_back('{0, 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
        vt.push_back('{1, 32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h0000000C, 1'b0});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.res_valid",  32'(res_valid),       32'd0);
        chk("rst.req_ready",  32'(req_ready),       32'd0);
        chk("rst.res_sum",    res_sum,              32'd0);
        chk("rst.res_cout",   32'(res_cout),        32'd0);
        chk("rst.res_last",   32'(res_last),        32'd0);
        chk("rst.res_id",     32'(res_id),          32'd0);
        chk("rst.state",      32'(dut.state),       32'(IDLE));
        chk("rst.carry",      32'(dut.carry_reg),   32'd0);
        chk("rst.grant",      32'(dut.grant),       32'd0);
        chk("rst.last_grant", 32'(dut.last_grant),  32'(NREQ - 1));
        rst_n = 1'b1;

        // Vector table: one result per accepted word, visible right after accept
        foreach (vt[i]) begin
            put_word(vt[i].id, vt[i].a, vt[i].b, vt[i].last, vt[i].sub, ok);
            if (ok) begin
                chk_res($sformatf("v%0d", i), vt[i].sum, vt[i].cout, vt[i].last, vt[i].id);
                if (vt[i].last) begin
                    chk($sformatf("v%0d.carry_clr", i), 32'(dut.carry_reg), 32'd0);
                    chk($sformatf("v%0d.idle", i),      32'(dut.state),     32'(IDLE));
                end
            end
        end

        // Round-robin: req0 and req2 keep requesting single-word bursts
        do_reset();
        req_a[0*32 +: 32] = 32'h10; req_b[0*32 +: 32] = 32'h1; req_last[0] = 1'b1; req_sub[0] = 1'b0;
        req_a[2*32 +: 32] = 32'h20; req_b[2*32 +: 32] = 32'h2; req_last[2] = 1'b1; req_sub[2] = 1'b0;
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                chk($sformatf("rr%0d.id", got),  32'(res_id), 32'(rr_id[got]));
                chk($sformatf("rr%0d.sum", got), res_sum,     rr_sum[got]);
                got++;
            end
        end
        req_valid = '0;
        chk("rr.count", 32'(got), 32'd4);
        repeat (3) @(posedge clk);
        #1;

        // Output stall mid-burst: held outputs, no ready, correct chained carry
        put_word(1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, ok);
        chk_res("st.w0", 32'h0, 1'b1, 1'b0, 1);
        res_ready = 1'b0;
        req_a[1*32 +: 32] = 32'h2;
        req_b[1*32 +: 32] = 32'h3;
        req_last[1]       = 1'b1;
        req_valid[1]      = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("st%0d.ready", c), 32'(req_ready[1]), 32'd0);
            chk($sformatf("st%0d.sum", c),   res_sum,           32'h0);
            chk($sformatf("st%0d.cout", c),  32'(res_cout),     32'd1);
            chk($sformatf("st%0d.valid", c), 32'(res_valid),    32'd1);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        chk_res("st.w1", 32'h6, 1'b0, 1'b1, 1);
        @(posedge clk);
        #1;
        chk("st.drained", 32'(res_valid), 32'd0);

        // Reset on the cycle after w0 of a 3-word burst
        put_word(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, ok);
        chk_res("mr.w0", 32'hFFFFFFFE, 1'b1, 1'b0, 3);
        req_a[3*32 +: 32] = 32'h0;
        req_b[3*32 +: 32] = 32'h0;
        req_last[3]       = 1'b0;
        req_valid[3]      = 1'b1;
        rst_n             = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        req_valid[3] = 1'b0;
        chk("mr.res_valid", 32'(res_valid),     32'd0);
        chk("mr.state",     32'(dut.state),     32'(IDLE));
        chk("mr.carry",     32'(dut.carry_reg), 32'd0);
        chk("mr.ready",     32'(req_ready),     32'd0);
        put_word(3, 32'h1, 32'h1, 1'b1, 1'b0, ok);
        chk_res("mr.fresh", 32'h2, 1'b0, 1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
